pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Upstream feeder for the PWM generator in the wb_pwm path. It exposes a Wishbone classic slave register file for the PWM period, target on-time, ramp step and enable. It drives the generator's period and time_work inputs, moving time_work toward the target by STEP once per PWM frame. Servos on the pet feeder therefore slew smoothly instead of jumping.

Parameters:
DW, 32, data width of registers, period_o and time_work_o
RST_PERIOD, 0, period_o value after reset
RST_STEP, 0, STEP register value after reset (0 = no ramp, immediate jump)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  5  byte address; register index = wb_adr_i[4:2]
wb_dat_i  in  DW  write data
wb_dat_o  out  DW  read data, registered
wb_ack_o  out  1  acknowledge, registered
period_o  out  DW  to PWM period input, in clk cycles
time_work_o  out  DW  to PWM time_work input, in clk cycles
busy_o  out  1  ramp in progress
done_o  out  1  one-cycle pulse when current reaches target

Behaviour:
- Reset (sync, active-high, wins over everything):
  - period_o=RST_PERIOD, step=RST_STEP, target=0, current=0, enable=0
  - time_work_o=0, wb_ack_o=0, wb_dat_o=0, busy_o=0, done_o=0
  - state=IDLE, frame counter=0
- Register map (index):
  - 0 PERIOD RW
  - 1 TARGET RW
  - 2 STEP RW
  - 3 CTRL RW: bit0 enable; read returns {DW-2 zeros, busy, enable}
  - 4 CURRENT RO
  - 5-7 unmapped: read 0, writes ignored, still acked
- Bus handshake:
  - wb_ack_o asserts the cycle after cyc&stb with ack low; it stays high for exactly 1 cycle.
  - Write takes effect on the ack edge; wb_dat_o is valid with ack.
  - No back-to-back ack: max one access per 2 cycles.
  - Write to CURRENT is ignored.
- Target clamp: when written, target = min(wb_dat_i, period_o). On a PERIOD write, target and current are both clamped to the new period on the same edge.
- Frame tick:
  - Counter runs 0..period_o-1 and pulses tick when it equals period_o-1, then wraps to 0.
  - period_o==0: counter held 0, no tick.
  - PERIOD write: counter restarts at 0.
- State machine (IDLE, RAMP):
  - IDLE -> RAMP when enable && current!=target. busy_o=1 in RAMP.
  - RAMP on tick: let diff=|target-current|, computed without wrap (compare first, then subtract).
    - If step==0 or diff<=step: current<=target, done_o=1 for that cycle, next state IDLE.
    - Else: current<=current±step toward target.
  - RAMP, enable cleared: return to IDLE, current frozen, no done.
  - TARGET write during RAMP: direction is recomputed from the new target at the next tick; no restart.
  - TARGET write equal to current: no state change, no done.
- Output:
  - time_work_o = enable ? current : 0 (registered, follows current with 1-cycle latency).
  - period_o = PERIOD register directly.
- Simultaneous events:
  - A bus write on a tick edge: the tick step uses pre-write target/step; the new values apply from the next tick.
  - Reset mid-ramp: all state cleared, done not asserted.

Decomposition:
- Package pwm_pkg:
  - register index constants REG_PERIOD..REG_CURRENT
  - CTRL bit positions
  - state enum {IDLE, RAMP}
- Sub-module frame_tick_gen (clk, reset, period, restart -> tick): the frame counter, reusable alongside the PWM generator.

Test Plan:
- Reset, then read all regs -> PERIOD=0, TARGET=0, STEP=0, CTRL=0, CURRENT=0; each ack exactly 1 cycle, 1 cycle after stb.
- PERIOD=20, STEP=3, enable=1, TARGET=10 -> time_work_o reads 3,6,9,10 on successive ticks (every 20 clks); done_o pulses once with the 10; busy_o falls the same cycle.
- From current=10, TARGET=2, STEP=4 -> 6, then 2, done; no underflow. Then TARGET=500 with PERIOD=20 -> TARGET reads back 20.
- STEP=0, TARGET=15 -> current=15 at first tick with done; PERIOD=0 -> no ticks, busy_o stays 1 until PERIOD=20 is written.
- Mid-ramp (current=6, heading to 10): clear enable -> time_work_o=0 next cycle, busy_o=0, CURRENT=6; set enable again -> ramp resumes 9,10.
- Assert reset mid-ramp -> all outputs 0 next cycle, no done_o; access to index 6 -> acked, reads 0.

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
// pwm_pkg: shared definitions for the PWM ramp controller.
// Holds the register index map, CTRL register bit positions and the
// ramp state machine encoding. Imported by pwm_ramp_ctrl and its bench.
package pwm_pkg;

  localparam logic [2:0] REG_PERIOD  = 3'd0;
  localparam logic [2:0] REG_TARGET  = 3'd1;
  localparam logic [2:0] REG_STEP    = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_CURRENT = 3'd4;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_BUSY_BIT   = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: Wishbone classic bus bundle for the PWM ramp controller.
// Signals (named from the slave's point of view):
//   wb_cyc_i, wb_stb_i, wb_we_i  - cycle, strobe, write enable
//   wb_adr_i[4:0]                - byte address, register index = [4:2]
//   wb_dat_i[DW-1:0]             - write data
//   wb_dat_o[DW-1:0]             - registered read data
//   wb_ack_o                     - registered single-cycle acknowledge
interface pwm_ramp_ctrl_if #(
  parameter int DW = 32
) ();

  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [4:0]    wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/pwm_ramp_ctrl_frame_tick_gen.sv
// frame_tick_gen: PWM frame counter.
// Counts 0..period-1 and raises tick for the cycle in which the count
// equals period-1, matching the frame boundary of the PWM generator.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   period      - frame length in clk cycles (0 = stopped, no ticks)
//   restart     - forces the count back to 0 (period reprogrammed)
//   tick        - one-cycle pulse at the last cycle of each frame
module frame_tick_gen #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] period,
  input  logic          restart,
  output logic          tick
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] count;
  logic [DW-1:0] last;

  assign last = period - ONE;
  assign tick = (period != '0) && (count == last);

  // Wrap on >= rather than == so a count left beyond a shrunken period
  // can never run away.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count <= '0;
    end else if (period == '0) begin
      count <= '0;
    end else if (count >= last) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: Wishbone register file feeding a PWM generator.
// Moves time_work_o toward TARGET by STEP once per PWM frame so servos
// slew smoothly.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   wb           - Wishbone classic slave (pwm_ramp_ctrl_if.slave)
//   period_o     - PERIOD register, to PWM period input
//   time_work_o  - enable ? CURRENT : 0, registered
//   busy_o       - ramp in progress
//   done_o       - one-cycle pulse when CURRENT reaches TARGET
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int          DW         = 32,
  parameter logic [DW-1:0] RST_PERIOD = '0,
  parameter logic [DW-1:0] RST_STEP   = '0
) (
  input  logic          clk,
  input  logic          reset,
  pwm_ramp_ctrl_if.slave wb,
  output logic [DW-1:0] period_o,
  output logic [DW-1:0] time_work_o,
  output logic          busy_o,
  output logic          done_o
);

  function automatic logic [DW-1:0] min_val(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [DW-1:0] target_q;
  logic [DW-1:0] step_q;
  logic [DW-1:0] current_q;
  logic          enable_q;
  ramp_state_t   state_q;
  ramp_state_t   state_d;
  logic [DW-1:0] current_step;
  logic [DW-1:0] current_d;
  logic [DW-1:0] diff;
  logic          move_up;
  logic          done_d;
  logic          tick;
  logic          access;
  logic          wr;
  logic [2:0]    idx;
  logic          wr_period;
  logic          wr_target;
  logic          wr_step;
  logic          wr_ctrl;
  logic [DW-1:0] rd_data;
  logic          adr_unused;

  // An access is accepted only while ack is low, which spaces
  // transactions at least two cycles apart.
  assign access    = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr        = access & wb.wb_we_i;
  assign idx       = wb.wb_adr_i[4:2];
  assign wr_period = wr && (idx == REG_PERIOD);
  assign wr_target = wr && (idx == REG_TARGET);
  assign wr_step   = wr && (idx == REG_STEP);
  assign wr_ctrl   = wr && (idx == REG_CTRL);
  assign adr_unused = ^wb.wb_adr_i[1:0];

  assign busy_o = (state_q == RAMP);

  frame_tick_gen #(.DW(DW)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .period  (period_o),
    .restart (wr_period),
    .tick    (tick)
  );

  // Read mux; unmapped indices read zero.
  always_comb begin
    rd_data = '0;
    case (idx)
      REG_PERIOD:  rd_data = period_o;
      REG_TARGET:  rd_data = target_q;
      REG_STEP:    rd_data = step_q;
      REG_CTRL: begin
        rd_data[CTRL_ENABLE_BIT] = enable_q;
        rd_data[CTRL_BUSY_BIT]   = busy_o;
      end
      REG_CURRENT: rd_data = current_q;
      default:     rd_data = '0;
    endcase
  end

  // Ramp next-state logic. The distance is formed by comparing first
  // and subtracting the smaller value so it never wraps. A step uses the
  // registered target/step, so a write landing on a tick edge only
  // affects the following tick.
  always_comb begin
    state_d      = state_q;
    current_step = current_q;
    done_d       = 1'b0;
    move_up      = (target_q >= current_q);
    diff         = move_up ? (target_q - current_q) : (current_q - target_q);
    case (state_q)
      IDLE: begin
        if (enable_q && (current_q != target_q)) begin
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (!enable_q) begin
          state_d = IDLE;
        end else if (tick) begin
          if ((step_q == '0) || (diff <= step_q)) begin
            current_step = target_q;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else if (move_up) begin
            current_step = current_q + step_q;
          end else begin
            current_step = current_q - step_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new period clamps the running value on the same edge.
    current_d = wr_period ? min_val(current_step, wb.wb_dat_i) : current_step;
  end

  // Register file, bus handshake and ramp state.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_o    <= RST_PERIOD;
      step_q      <= RST_STEP;
      target_q    <= '0;
      current_q   <= '0;
      enable_q    <= 1'b0;
      state_q     <= IDLE;
      done_o      <= 1'b0;
      time_work_o <= '0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= access;
      if (access) begin
        wb.wb_dat_o <= rd_data;
      end
      if (wr_period) begin
        period_o <= wb.wb_dat_i;
        target_q <= min_val(target_q, wb.wb_dat_i);
      end
      if (wr_target) begin
        target_q <= min_val(wb.wb_dat_i, period_o);
      end
      if (wr_step) begin
        step_q <= wb.wb_dat_i;
      end
      if (wr_ctrl) begin
        enable_q <= wb.wb_dat_i[CTRL_ENABLE_BIT];
      end
      current_q   <= current_d;
      state_q     <= state_d;
      done_o      <= done_d;
      time_work_o <= enable_q ? current_q : '0;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed self-checking bench for pwm_ramp_ctrl.
// Drives the Wishbone bundle through bus tasks, follows time_work_o
// frame by frame and counts done_o pulses with a small monitor.
module tb_pwm_ramp_ctrl;
  import pwm_pkg::*;

  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic [DW-1:0] period_o;
  logic [DW-1:0] time_work_o;
  logic          busy_o;
  logic          done_o;

  int          testCount = 0;
  int          failCount = 0;
  int          doneCount = 0;
  logic        busyAtDone = 1'b1;
  logic [31:0] lastTw = '0;
  logic [31:0] rdData;

  pwm_ramp_ctrl_if #(.DW(DW)) bus ();

  pwm_ramp_ctrl #(.DW(DW), .RST_PERIOD('0), .RST_STEP('0)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (bus.slave),
    .period_o    (period_o),
    .time_work_o (time_work_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completion pulses and note busy_o in the same cycle.
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      doneCount++;
      busyAtDone = busy_o;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic busWrite(input string tag, input logic [2:0] idx,
                          input logic [31:0] data);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = {idx, 2'b00};
    bus.wb_dat_i = data;
    @(posedge clk);
    #1;
    checkOutput({tag, "_ack"}, {31'd0, bus.wb_ack_o}, 32'd1);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic busRead(input string tag, input logic [2:0] idx,
                         output logic [31:0] data);
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = {idx, 2'b00};
    @(posedge clk);
    #1;
    checkOutput({tag, "_ack_rise"}, {31'd0, bus.wb_ack_o}, 32'd1);
    data = bus.wb_dat_o;
    @(negedge clk);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_ack_fall"}, {31'd0, bus.wb_ack_o}, 32'd0);
  endtask

  task automatic readCheck(input string tag, input logic [2:0] idx,
                           input logic [31:0] expected);
    logic [31:0] value;
    busRead(tag, idx, value);
    checkOutput(tag, value, expected);
  endtask

  // Wait for the next change of time_work_o and check the new value and,
  // when expGap >= 0, the number of cycles since the call started.
  task automatic waitTw(input string tag, input logic [31:0] expVal,
                        input int expGap);
    int cycles = 0;
    while (cycles < 30) begin
      @(posedge clk);
      #1;
      cycles++;
      if (time_work_o !== lastTw) break;
    end
    checkOutput(tag, time_work_o, expVal);
    if (expGap >= 0) checkOutput({tag, "_gap"}, cycles, expGap);
    lastTw = expVal;
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and register read-back.
    checkOutput("rst_period_o", period_o, 0);
    checkOutput("rst_time_work", time_work_o, 0);
    checkOutput("rst_busy", {31'd0, busy_o}, 0);
    checkOutput("rst_done", {31'd0, done_o}, 0);
    checkOutput("rst_ack", {31'd0, bus.wb_ack_o}, 0);
    readCheck("rst_rd_period", REG_PERIOD, 0);
    readCheck("rst_rd_target", REG_TARGET, 0);
    readCheck("rst_rd_step", REG_STEP, 0);
    readCheck("rst_rd_ctrl", REG_CTRL, 0);
    readCheck("rst_rd_current", REG_CURRENT, 0);

    // Ramp 0 -> 10 in steps of 3, one step per 20-cycle frame.
    busWrite("wr_period20", REG_PERIOD, 20);
    busWrite("wr_step3", REG_STEP, 3);
    busWrite("wr_en", REG_CTRL, 1);
    busWrite("wr_target10", REG_TARGET, 10);
    lastTw = 0;
    waitTw("up_3", 3, -1);
    waitTw("up_6", 6, 20);
    waitTw("up_9", 9, 20);
    checkOutput("up_no_done_yet", doneCount, 0);
    waitTw("up_10", 10, 20);
    checkOutput("up_done_once", doneCount, 1);
    checkOutput("up_busy_at_done", {31'd0, busyAtDone}, 0);
    checkOutput("up_busy_after", {31'd0, busy_o}, 0);
    checkOutput("up_period_o", period_o, 20);
    readCheck("up_rd_current", REG_CURRENT, 10);

    // Ramp down 10 -> 2 by 4, last step lands exactly.
    busWrite("wr_step4", REG_STEP, 4);
    busWrite("wr_target2", REG_TARGET, 2);
    waitTw("dn_6", 6, -1);
    waitTw("dn_2", 2, 20);
    checkOutput("dn_done", doneCount, 2);

    // Target clamp while disabled.
    busWrite("wr_dis", REG_CTRL, 0);
    lastTw = 0;
    checkOutput("dis_time_work", time_work_o, 0);
    busWrite("wr_target500", REG_TARGET, 500);
    readCheck("clamp_target", REG_TARGET, 20);

    // STEP=0 jumps straight to the target on the first tick.
    busWrite("wr_step0", REG_STEP, 0);
    busWrite("wr_target15", REG_TARGET, 15);
    busWrite("wr_en2", REG_CTRL, 1);
    checkOutput("jump_resume_tw", time_work_o, 2);
    lastTw = 2;
    waitTw("jump_15", 15, -1);
    checkOutput("jump_done", doneCount, 3);
    readCheck("jump_rd_current", REG_CURRENT, 15);

    // Period 0 stops ticks; the pending ramp waits until a period returns.
    busWrite("wr_period20b", REG_PERIOD, 20);
    busWrite("wr_target5", REG_TARGET, 5);
    busWrite("wr_period0", REG_PERIOD, 0);
    repeat (60) @(posedge clk);
    #1;
    checkOutput("p0_busy", {31'd0, busy_o}, 1);
    checkOutput("p0_no_done", doneCount, 3);
    checkOutput("p0_time_work", time_work_o, 0);
    readCheck("p0_rd_target", REG_TARGET, 0);
    busWrite("wr_period20c", REG_PERIOD, 20);
    for (int i = 0; i < 30 && doneCount == 3; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("p0_done_after", doneCount, 4);
    checkOutput("p0_idle_after", {31'd0, busy_o}, 0);

    // Pause mid-ramp by clearing enable, then resume.
    busWrite("wr_step3b", REG_STEP, 3);
    busWrite("wr_target10b", REG_TARGET, 10);
    lastTw = 0;
    waitTw("mid_3", 3, -1);
    waitTw("mid_6", 6, 20);
    busWrite("wr_pause", REG_CTRL, 0);
    checkOutput("pause_tw", time_work_o, 0);
    checkOutput("pause_busy", {31'd0, busy_o}, 0);
    readCheck("pause_rd_current", REG_CURRENT, 6);
    busWrite("wr_resume", REG_CTRL, 1);
    checkOutput("resume_tw", time_work_o, 6);
    lastTw = 6;
    waitTw("resume_9", 9, -1);
    waitTw("resume_10", 10, 20);
    checkOutput("resume_done", doneCount, 5);

    // Reset in the middle of a downward ramp.
    busWrite("wr_target1", REG_TARGET, 1);
    waitTw("rr_7", 7, -1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rr_period_o", period_o, 0);
    checkOutput("rr_time_work", time_work_o, 0);
    checkOutput("rr_busy", {31'd0, busy_o}, 0);
    checkOutput("rr_done", {31'd0, done_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rr_no_done", doneCount, 5);

    // Unmapped indices and the read-only CURRENT register.
    readCheck("rd_idx6", 3'd6, 0);
    busWrite("wr_idx7", 3'd7, 123);
    readCheck("rd_idx7", 3'd7, 0);
    busWrite("wr_current", REG_CURRENT, 77);
    readCheck("rd_current_ro", REG_CURRENT, 0);
    readCheck("rr_rd_ctrl", REG_CTRL, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
